// File: rtl/move_controller.sv
// rtl/move_controller.sv - turn-sequencing FSM driving one-hot board write enables
// Optional per-turn forfeit timer enabled by defining MOVE_TIMEOUT_EN.
module move_controller #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_W           = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       play,
    input  logic       pc,
    input  logic [3:0] sel,
    input  logic [1:0] pos1,
    input  logic [1:0] pos2,
    input  logic [1:0] pos3,
    input  logic [1:0] pos4,
    input  logic [1:0] pos5,
    input  logic [1:0] pos6,
    input  logic [1:0] pos7,
    input  logic [1:0] pos8,
    input  logic [1:0] pos9,
    input  logic       win_detected,
    output logic [9:1] PL_en,
    output logic [9:1] PL2_en,
    output logic       illegal_move,
    output logic       turn,
    output logic [3:0] move_count,
    output logic       no_space,
    output logic       game_over,
    output logic       timeout
);

    typedef enum logic [2:0] {
        WAIT_P1   = 3'd0,
        WAIT_P2   = 3'd1,
        SETTLE_P1 = 3'd2,
        SETTLE_P2 = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic       play_q, pc_q;
    logic [9:1] pl_en_q, pl_en_d;
    logic [9:1] pl2_en_q, pl2_en_d;
    logic       illegal_q, illegal_d;
    logic       turn_q, turn_d;
    logic [3:0] count_q, count_d;
    logic       no_space_q, no_space_d;
    logic       game_over_q, game_over_d;
    logic       timeout_q, timeout_d;

    logic [1:0] sel_pos;
    logic       sel_legal;
    logic [9:1] sel_onehot;
    logic       in_wait;
    logic       live;
    logic       cur_req;
    logic       expire;

    // Out-of-range selects decode to a non-empty code so they fail the same test.
    always_comb begin
        case (sel)
            4'd1:    sel_pos = pos1;
            4'd2:    sel_pos = pos2;
            4'd3:    sel_pos = pos3;
            4'd4:    sel_pos = pos4;
            4'd5:    sel_pos = pos5;
            4'd6:    sel_pos = pos6;
            4'd7:    sel_pos = pos7;
            4'd8:    sel_pos = pos8;
            4'd9:    sel_pos = pos9;
            default: sel_pos = 2'b11;
        endcase
    end

    assign sel_legal  = (sel_pos == 2'b00);
    assign sel_onehot = 9'b1 << (sel - 4'd1);
    assign in_wait    = (state_q == WAIT_P1) || (state_q == WAIT_P2);
    assign live       = in_wait && !win_detected;

    // Only the player whose turn it is can raise a request.
    always_comb begin
        case (state_q)
            WAIT_P1: cur_req = play & ~play_q;
            WAIT_P2: cur_req = pc & ~pc_q;
            default: cur_req = 1'b0;
        endcase
    end

`ifdef MOVE_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    assign expire = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (((state_d == WAIT_P1) || (state_d == WAIT_P2)) && (state_d != state_q))
            to_cnt_d = '0;
        else if (in_wait)
            to_cnt_d = to_cnt_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) to_cnt_q <= '0;
        else        to_cnt_q <= to_cnt_d;
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= WAIT_P1;
            play_q      <= 1'b0;
            pc_q        <= 1'b0;
            pl_en_q     <= '0;
            pl2_en_q    <= '0;
            illegal_q   <= 1'b0;
            turn_q      <= 1'b0;
            count_q     <= 4'd0;
            no_space_q  <= 1'b0;
            game_over_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            play_q      <= play;
            pc_q        <= pc;
            pl_en_q     <= pl_en_d;
            pl2_en_q    <= pl2_en_d;
            illegal_q   <= illegal_d;
            turn_q      <= turn_d;
            count_q     <= count_d;
            no_space_q  <= no_space_d;
            game_over_q <= game_over_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_P1: begin
                if (win_detected)              state_d = DONE;
                else if (cur_req && sel_legal) state_d = SETTLE_P1;
                else if (!cur_req && expire)   state_d = WAIT_P2;
            end
            WAIT_P2: begin
                if (win_detected)              state_d = DONE;
                else if (cur_req && sel_legal) state_d = SETTLE_P2;
                else if (!cur_req && expire)   state_d = WAIT_P1;
            end
            SETTLE_P1: state_d = (win_detected || count_q == 4'd9) ? DONE : WAIT_P2;
            SETTLE_P2: state_d = (win_detected || count_q == 4'd9) ? DONE : WAIT_P1;
            default:   state_d = DONE;
        endcase
    end

    always_comb begin
        pl_en_d     = '0;
        pl2_en_d    = '0;
        illegal_d   = 1'b0;
        timeout_d   = 1'b0;
        turn_d      = turn_q;
        count_d     = count_q;
        game_over_d = game_over_q || (state_d == DONE);
        if (live && cur_req && sel_legal) begin
            if (state_q == WAIT_P1) pl_en_d  = sel_onehot;
            else                    pl2_en_d = sel_onehot;
            count_d = (count_q == 4'd9) ? count_q : count_q + 4'd1;
            turn_d  = ~turn_q;
        end else if (live && cur_req) begin
            illegal_d = 1'b1;
        end else if (live && expire) begin
            timeout_d = 1'b1;
            turn_d    = ~turn_q;
        end
        no_space_d = (count_d == 4'd9);
    end

    assign PL_en        = pl_en_q;
    assign PL2_en       = pl2_en_q;
    assign illegal_move = illegal_q;
    assign turn         = turn_q;
    assign move_count   = count_q;
    assign no_space     = no_space_q;
    assign game_over    = game_over_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_move_controller.sv
// tb/tb_move_controller.sv - directed self-checking bench for move_controller
module tb_move_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       play = 1'b0;
    logic       pc = 1'b0;
    logic [3:0] sel = 4'd0;
    logic [1:0] pos [1:9];
    logic       win_detected = 1'b0;
    logic [9:1] PL_en, PL2_en;
    logic       illegal_move, turn, no_space, game_over, timeout;
    logic [3:0] move_count;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    move_controller #(.TIMEOUT_CYCLES(8), .TO_W(4)) dut (
        .clock(clock), .reset(reset), .play(play), .pc(pc), .sel(sel),
        .pos1(pos[1]), .pos2(pos[2]), .pos3(pos[3]), .pos4(pos[4]), .pos5(pos[5]),
        .pos6(pos[6]), .pos7(pos[7]), .pos8(pos[8]), .pos9(pos[9]),
        .win_detected(win_detected), .PL_en(PL_en), .PL2_en(PL2_en),
        .illegal_move(illegal_move), .turn(turn), .move_count(move_count),
        .no_space(no_space), .game_over(game_over), .timeout(timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        play = 1'b0;
        pc = 1'b0;
        win_detected = 1'b0;
        sel = 4'd0;
        for (int i = 1; i <= 9; i++) pos[i] = 2'b00;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // p=0 player 1, p=1 player 2; w is the winner-checker level during SETTLE
    task automatic do_move(input bit p, input int s, input bit w, input int exp_cnt);
        logic [8:0] exp_en;
        exp_en = 9'b1 << (s - 1);
        sel = 4'(s);
        if (!p) play = 1'b1;
        else    pc   = 1'b1;
        tick();
        check("move_en",    32'(p ? PL2_en : PL_en), 32'(exp_en));
        check("move_other", 32'(p ? PL_en : PL2_en), 32'd0);
        check("move_cnt",   32'(move_count), 32'(exp_cnt));
        check("move_turn",  32'(turn), 32'(!p));
        check("move_ill",   32'(illegal_move), 32'd0);
        play = 1'b0;
        pc = 1'b0;
        pos[s] = p ? 2'b10 : 2'b01;
        win_detected = w;
        tick();
        check("move_en_clr", 32'(PL_en | PL2_en), 32'd0);
    endtask

    initial begin
        int pulses;
        for (int i = 1; i <= 9; i++) pos[i] = 2'b00;

        do_reset();
        check("rst_pl_en",  32'(PL_en), 32'd0);
        check("rst_pl2_en", 32'(PL2_en), 32'd0);
        check("rst_ill",    32'(illegal_move), 32'd0);
        check("rst_turn",   32'(turn), 32'd0);
        check("rst_cnt",    32'(move_count), 32'd0);
        check("rst_nospace",32'(no_space), 32'd0);
        check("rst_gover",  32'(game_over), 32'd0);
        check("rst_tmo",    32'(timeout), 32'd0);
        sel = 4'd5;
        pc = 1'b1;
        tick();
        check("p2_ignored_en",  32'(PL_en | PL2_en), 32'd0);
        check("p2_ignored_ill", 32'(illegal_move), 32'd0);
        pc = 1'b0;
        tick();

        do_reset();
        sel = 4'd3;
        play = 1'b1;
        tick();
        check("legal_pl_en", 32'(PL_en), 32'(9'b000000100));
        check("legal_turn",  32'(turn), 32'd1);
        check("legal_cnt",   32'(move_count), 32'd1);
        play = 1'b0;
        pos[3] = 2'b01;
        tick();
        check("legal_pulse_end", 32'(PL_en), 32'd0);
        tick();
        pc = 1'b1;
        tick();
        check("occ_ill",    32'(illegal_move), 32'd1);
        check("occ_pl2_en", 32'(PL2_en), 32'd0);
        check("occ_turn",   32'(turn), 32'd1);
        pc = 1'b0;
        tick();
        check("occ_ill_end", 32'(illegal_move), 32'd0);

        do_reset();
        sel = 4'd0;
        play = 1'b1;
        tick();
        check("sel0_ill", 32'(illegal_move), 32'd1);
        play = 1'b0;
        tick();
        sel = 4'd12;
        play = 1'b1;
        tick();
        check("sel12_ill", 32'(illegal_move), 32'd1);
        check("sel12_en",  32'(PL_en), 32'd0);
        play = 1'b0;
        tick();
        check("oor_cnt",  32'(move_count), 32'd0);
        check("oor_turn", 32'(turn), 32'd0);

        sel = 4'd1;
        play = 1'b1;
        tick();
        check("mid_pl_en", 32'(PL_en), 32'd1);
        reset = 1'b0;
        play = 1'b0;
        tick();
        check("midrst_en",   32'(PL_en), 32'd0);
        check("midrst_cnt",  32'(move_count), 32'd0);
        check("midrst_turn", 32'(turn), 32'd0);
        reset = 1'b1;

        do_reset();
        for (int m = 1; m <= 9; m++) do_move(bit'((m - 1) % 2), m, 1'b0, m);
        check("full_nospace", 32'(no_space), 32'd1);
        check("full_gover",   32'(game_over), 32'd1);
        sel = 4'd5;
        pc = 1'b1;
        play = 1'b1;
        tick();
        check("full_10_en",  32'(PL_en | PL2_en), 32'd0);
        check("full_10_ill", 32'(illegal_move), 32'd0);
        check("full_10_cnt", 32'(move_count), 32'd9);
        pc = 1'b0;
        play = 1'b0;
        tick();

        do_reset();
        for (int m = 1; m <= 4; m++) do_move(bit'((m - 1) % 2), m, 1'b0, m);
        check("win_pre_gover", 32'(game_over), 32'd0);
        do_move(1'b0, 5, 1'b1, 5);
        check("win_gover", 32'(game_over), 32'd1);
        check("win_cnt",   32'(move_count), 32'd5);
        win_detected = 1'b0;
        sel = 4'd9;
        pc = 1'b1;
        tick();
        check("win_ign_en",  32'(PL_en | PL2_en), 32'd0);
        check("win_ign_ill", 32'(illegal_move), 32'd0);
        pc = 1'b0;
        play = 1'b1;
        tick();
        check("win_ign_p1", 32'(PL_en), 32'd0);
        check("win_hold_cnt", 32'(move_count), 32'd5);
        play = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("win_rst_turn",  32'(turn), 32'd0);
        check("win_rst_cnt",   32'(move_count), 32'd0);
        check("win_rst_gover", 32'(game_over), 32'd0);

        do_reset();
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            if (timeout === 1'b1) pulses++;
            tick();
        end
`ifdef MOVE_TIMEOUT_EN
        check("tmo_pulses", 32'(pulses), 32'd1);
        check("tmo_turn",   32'(turn), 32'd1);
`else
        check("tmo_pulses", 32'(pulses), 32'd0);
        check("tmo_turn",   32'(turn), 32'd0);
`endif
        check("tmo_cnt", 32'(move_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
